// File: rtl/fix_msg_relay.sv
// Per-channel FIX message relay: captures one framed message per ingress channel
// and replays it to the paired channel (c ^ 1) with a new-message strobe and backpressure.
module fix_msg_relay #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned SKIP_BYTES = 1,
  parameter int unsigned LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          fifo_write_i,
  input  logic [NUM_CH*DATA_W-1:0]   message_i,
  input  logic [NUM_CH-1:0]          end_i,
  input  logic [NUM_CH-1:0]          full_i,
  output logic [NUM_CH-1:0]          new_message_o,
  output logic [NUM_CH*DATA_W-1:0]   message_o,
  output logic [NUM_CH-1:0]          valid_o,
  output logic [NUM_CH-1:0]          busy_o,
  output logic [NUM_CH-1:0]          drop_o,
  output logic [NUM_CH-1:0]          overflow_o
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SKIP_W = $clog2(SKIP_BYTES + 2);

  typedef enum logic [1:0] {IDLE, CAPTURE, READY, REPLAY} state_t;

  state_t            state    [NUM_CH];
  logic [SKIP_W-1:0] skip_cnt [NUM_CH];
  logic [SKIP_W-1:0] skip_nx  [NUM_CH];
  logic [LEN_W-1:0]  wr_ptr   [NUM_CH];
  logic [LEN_W-1:0]  wp_base  [NUM_CH];
  logic [LEN_W-1:0]  wp_nx    [NUM_CH];
  logic [LEN_W-1:0]  rd_ptr   [NUM_CH];
  logic [LEN_W-1:0]  rd_base  [NUM_CH];
  logic [LEN_W-1:0]  len      [NUM_CH];
  logic [NUM_CH-1:0] msg_ovf;
  logic [NUM_CH-1:0] of_nx;
  logic [NUM_CH-1:0] store;
  logic [NUM_CH-1:0] ovf_hit;
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

  // Capture datapath: skip leading bytes, then store or flag overflow.
  // IDLE restarts counters so a message can begin on any cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      skip_nx[c] = (state[c] == IDLE) ? SKIP_W'(SKIP_BYTES) : skip_cnt[c];
      wp_base[c] = (state[c] == IDLE) ? '0 : wr_ptr[c];
      rd_base[c] = (state[c] == READY) ? '0 : rd_ptr[c];
      wp_nx[c]   = wp_base[c];
      of_nx[c]   = (state[c] == CAPTURE) & msg_ovf[c];
      store[c]   = 1'b0;
      ovf_hit[c] = 1'b0;
      if ((state[c] == IDLE || state[c] == CAPTURE) && fifo_write_i[c]) begin
        if (skip_nx[c] != '0) begin
          skip_nx[c] = skip_nx[c] - SKIP_W'(1);
        end else if (wp_base[c] == LEN_W'(DEPTH)) begin
          ovf_hit[c] = 1'b1;
          of_nx[c]   = 1'b1;
        end else begin
          store[c] = 1'b1;
          wp_nx[c] = wp_base[c] + LEN_W'(1);
        end
      end
    end
  end

  // Message buffers, no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (store[c]) mem[c][AW'(wp_base[c])] <= message_i[c*DATA_W +: DATA_W];
    end
  end

  // Per-ingress FSM; replay outputs land on the peer channel's ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_message_o <= '0;
      message_o     <= '0;
      valid_o       <= '0;
      busy_o        <= '0;
      drop_o        <= '0;
      overflow_o    <= '0;
      msg_ovf       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]    <= IDLE;
        skip_cnt[c] <= '0;
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        len[c]      <= '0;
      end
    end else begin
      new_message_o <= '0;
      valid_o       <= '0;
      drop_o        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        case (state[c])
          IDLE, CAPTURE: begin
            skip_cnt[c] <= skip_nx[c];
            wr_ptr[c]   <= wp_nx[c];
            msg_ovf[c]  <= of_nx[c];
            if (ovf_hit[c]) begin
              overflow_o[c] <= 1'b1;
              drop_o[c]     <= 1'b1;
            end
            if (end_i[c]) begin
              if (of_nx[c]) begin
                state[c] <= IDLE;
              end else if (wp_nx[c] == '0) begin
                drop_o[c] <= 1'b1;
                state[c]  <= IDLE;
              end else begin
                state[c]             <= READY;
                len[c]               <= wp_nx[c];
                busy_o[c]            <= 1'b1;
                new_message_o[c ^ 1] <= 1'b1;
              end
            end else if (fifo_write_i[c]) begin
              state[c] <= CAPTURE;
            end
          end
          READY, REPLAY: begin
            if (fifo_write_i[c] || end_i[c]) drop_o[c] <= 1'b1;
            if (rd_base[c] == len[c]) begin
              state[c]  <= IDLE;
              busy_o[c] <= 1'b0;
            end else begin
              state[c] <= REPLAY;
              if (!full_i[c ^ 1]) begin
                valid_o[c ^ 1]                    <= 1'b1;
                message_o[(c ^ 1)*DATA_W +: DATA_W] <= mem[c][AW'(rd_base[c])];
                rd_ptr[c]                         <= rd_base[c] + LEN_W'(1);
              end else begin
                rd_ptr[c] <= rd_base[c];
              end
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fix_msg_relay.sv
// Directed bench for fix_msg_relay: a default-depth instance and a DEPTH=4 instance
// share all inputs; each scenario task checks its own expectations inline.
module tb_fix_msg_relay;

  logic        clk;
  logic        rst;
  logic [1:0]  fw;
  logic [15:0] msg;
  logic [1:0]  en;
  logic [1:0]  full;

  logic [1:0]  nm, vo, bz, dr, ov;
  logic [15:0] mo;
  logic [1:0]  s_nm, s_vo, s_bz, s_dr, s_ov;
  logic [15:0] s_mo;

  int passed = 0;
  int total  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] qs1[$];
  int nm_cnt0, nm_cnt1, drop_cnt0, s_nm1, s_drop0, overlap;

  fix_msg_relay #(.NUM_CH(2), .DATA_W(8), .DEPTH(512), .SKIP_BYTES(1)) dut (
    .clk(clk), .rst(rst), .fifo_write_i(fw), .message_i(msg), .end_i(en), .full_i(full),
    .new_message_o(nm), .message_o(mo), .valid_o(vo), .busy_o(bz), .drop_o(dr),
    .overflow_o(ov)
  );

  fix_msg_relay #(.NUM_CH(2), .DATA_W(8), .DEPTH(4), .SKIP_BYTES(1)) dut_s (
    .clk(clk), .rst(rst), .fifo_write_i(fw), .message_i(msg), .end_i(en), .full_i(full),
    .new_message_o(s_nm), .message_o(s_mo), .valid_o(s_vo), .busy_o(s_bz), .drop_o(s_dr),
    .overflow_o(s_ov)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack_q(input logic [7:0] q[$]);
    logic [63:0] r = '0;
    foreach (q[i]) r = {r[55:0], q[i]};
    return r;
  endfunction

  task automatic clear_stats();
    q0.delete(); q1.delete(); qs1.delete();
    nm_cnt0 = 0; nm_cnt1 = 0; drop_cnt0 = 0; s_nm1 = 0; s_drop0 = 0; overlap = 0;
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (vo[0]) q0.push_back(mo[7:0]);
    if (vo[1]) q1.push_back(mo[15:8]);
    if (nm[0]) nm_cnt0++;
    if (nm[1]) nm_cnt1++;
    if (dr[0]) drop_cnt0++;
    if ((nm & vo) != 2'b00) overlap++;
    if (s_vo[1]) qs1.push_back(s_mo[15:8]);
    if (s_nm[1]) s_nm1++;
    if (s_dr[0]) s_drop0++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input int ch, input logic [7:0] b);
    fw[ch] = 1'b1;
    msg[ch*8 +: 8] = b;
    tick();
    fw[ch] = 1'b0;
  endtask

  // Leading connect byte, payload, then end_i on its own cycle.
  task automatic send_msg(input int ch, input string s);
    send_byte(ch, 8'h00);
    for (int i = 0; i < s.len(); i++) send_byte(ch, s[i]);
    en[ch] = 1'b1;
    tick();
    en[ch] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    total++;
    if ({nm, vo, bz, dr, ov} !== 10'h0) $display("FAIL reset_flags: got %h want 000", {nm, vo, bz, dr, ov});
    else passed++;
    total++;
    if (mo !== 16'h0) $display("FAIL reset_data: got %h want 0000", mo);
    else passed++;
    total++;
    if ({s_nm, s_vo, s_bz, s_dr, s_ov} !== 10'h0) $display("FAIL reset_small: got %h want 000", {s_nm, s_vo, s_bz, s_dr, s_ov});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [39:0] exp_s;
    logic [7:0]  exp_b;
    exp_s = "8=FIX";
    clear_stats();
    send_msg(0, "8=FIX");
    total++;
    if ({nm[1], vo[1], bz[0]} !== 3'b101) $display("FAIL basic_strobe: nm/vo/busy got %b want 101", {nm[1], vo[1], bz[0]});
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_b = exp_s[39-8*i -: 8];
      total++;
      if ({vo[1], mo[15:8]} !== {1'b1, exp_b})
        $display("FAIL basic_byte%0d: valid/data got %b/%h want 1/%h", i, vo[1], mo[15:8], exp_b);
      else passed++;
    end
    tick();
    total++;
    if ({vo[1], bz[0]} !== 2'b00) $display("FAIL basic_done: valid/busy got %b want 00", {vo[1], bz[0]});
    else passed++;
    total++;
    if (nm_cnt1 !== 1 || overlap !== 0) $display("FAIL basic_counts: nm=%0d overlap=%0d want 1/0", nm_cnt1, overlap);
    else passed++;
  endtask

  task automatic test_backpressure();
    int low;
    logic held;
    clear_stats();
    send_msg(0, "8=FIX");
    tick();
    full[1] = 1'b1;
    low = 0;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!vo[1]) low++;
      if (mo[15:8] !== 8'h38) held = 1'b0;
    end
    full[1] = 1'b0;
    idle(6);
    total++;
    if (low !== 3) $display("FAIL bp_stall: valid-low cycles got %0d want 3", low);
    else passed++;
    total++;
    if (held !== 1'b1) $display("FAIL bp_hold: data changed while stalled, last %h want 38", mo[15:8]);
    else passed++;
    total++;
    if (q1.size() !== 5 || pack_q(q1) !== 64'h383D464958)
      $display("FAIL bp_stream: got %0d bytes %h want 5 bytes 383d464958", q1.size(), pack_q(q1));
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    clear_stats();
    send_msg(0, "ABCDEF");
    idle(10);
    total++;
    if (s_ov[0] !== 1'b1) $display("FAIL ovf_flag: got %b want 1", s_ov[0]);
    else passed++;
    total++;
    if (s_drop0 !== 2) $display("FAIL ovf_drops: got %0d want 2", s_drop0);
    else passed++;
    total++;
    if (s_nm1 !== 0 || qs1.size() !== 0) $display("FAIL ovf_noreplay: nm=%0d bytes=%0d want 0/0", s_nm1, qs1.size());
    else passed++;
    clear_stats();
    send_msg(0, "xyz");
    idle(8);
    total++;
    if (s_nm1 !== 1 || pack_q(qs1) !== 64'h78797A)
      $display("FAIL ovf_next: nm=%0d stream=%h want 1/78797a", s_nm1, pack_q(qs1));
    else passed++;
    total++;
    if (s_ov[0] !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", s_ov[0]);
    else passed++;
  endtask

  task automatic test_zero_len();
    clear_stats();
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    total++;
    if (dr[0] !== 1'b1) $display("FAIL zero_end_alone: drop got %b want 1", dr[0]);
    else passed++;
    tick();
    send_byte(0, 8'h00);
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    total++;
    if (dr[0] !== 1'b1) $display("FAIL zero_skip_only: drop got %b want 1", dr[0]);
    else passed++;
    idle(4);
    total++;
    if (nm_cnt1 !== 0 || bz[0] !== 1'b0 || drop_cnt0 !== 2)
      $display("FAIL zero_after: nm=%0d busy=%b drops=%0d want 0/0/2", nm_cnt1, bz[0], drop_cnt0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    string s0, s1;
    s0 = "abc";
    s1 = "PQRS";
    clear_stats();
    fw = 2'b11;
    msg = 16'h0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      msg = {s1[i], s0[i]};
      tick();
    end
    fw = 2'b10;
    en = 2'b01;
    msg = {s1[3], 8'h00};
    tick();
    fw = 2'b00;
    en = 2'b10;
    tick();
    en = 2'b00;
    fw[0] = 1'b1;
    msg[7:0] = 8'h5A;
    tick();
    fw[0] = 1'b0;
    idle(8);
    total++;
    if (pack_q(q1) !== 64'h616263) $display("FAIL b2b_ch1_stream: got %h want 616263", pack_q(q1));
    else passed++;
    total++;
    if (pack_q(q0) !== 64'h50515253) $display("FAIL b2b_ch0_stream: got %h want 50515253", pack_q(q0));
    else passed++;
    total++;
    if (nm_cnt0 !== 1 || nm_cnt1 !== 1) $display("FAIL b2b_strobes: nm0=%0d nm1=%0d want 1/1", nm_cnt0, nm_cnt1);
    else passed++;
    total++;
    if (drop_cnt0 !== 1) $display("FAIL b2b_busy_drop: drops got %0d want 1", drop_cnt0);
    else passed++;
    total++;
    if (overlap !== 0) $display("FAIL b2b_overlap: got %0d want 0", overlap);
    else passed++;
  endtask

  task automatic test_reset_mid();
    clear_stats();
    send_msg(0, "8=FIX");
    idle(2);
    rst = 1'b1;
    tick();
    total++;
    if ({nm, vo, bz, dr, ov} !== 10'h0 || mo !== 16'h0)
      $display("FAIL rstmid_outputs: flags %h data %h want 000/0000", {nm, vo, bz, dr, ov}, mo);
    else passed++;
    rst = 1'b0;
    idle(8);
    total++;
    if (q1.size() !== 2 || nm_cnt1 !== 1) $display("FAIL rstmid_abort: bytes=%0d nm=%0d want 2/1", q1.size(), nm_cnt1);
    else passed++;
    clear_stats();
    send_msg(0, "8=FIX");
    idle(8);
    total++;
    if (pack_q(q1) !== 64'h383D464958 || nm_cnt1 !== 1)
      $display("FAIL rstmid_fresh: stream=%h nm=%0d want 383d464958/1", pack_q(q1), nm_cnt1);
    else passed++;
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    fw   = '0;
    msg  = '0;
    en   = '0;
    full = '0;
    clear_stats();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
